// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control unit for the YouseiOS processor.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and stalls on
// console input (WAIT_IN) and HD transfers (WAIT_HD).
// Optional macro HD_TIMEOUT_EN: bounds the WAIT_HD stall to HD_TIMEOUT cycles.
module unidade_controle_multiciclo #(
    parameter int OPCODE_W   = 6,
    parameter int OPALU_W    = 6,
    parameter int ESTADO_W   = 4,
    parameter int HD_TIMEOUT = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                InValid,
    input  logic                HdReady,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                OpIO,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                AluSrc,
    output logic                RegDst,
    output logic                Desvio,
    output logic                TypeJR,
    output logic                WriteHD,
    output logic                Halt,
    output logic [1:0]          Mem2Reg,
    output logic [OPALU_W-1:0]  OpALU,
    output logic                HdErro,
    output logic [ESTADO_W-1:0] Estado
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXEC    = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        WAIT_IN = 3'd5,
        WAIT_HD = 3'd6,
        HALTED  = 3'd7
    } estado_t;

    typedef enum logic [3:0] {
        C_ALUR, C_ALUI, C_LOAD, C_STORE, C_JUMP, C_BRANCH, C_JR,
        C_IN, C_OUT, C_HDW, C_HDR, C_HALT, C_OTHER
    } classe_t;

    estado_t             estado, proximo;
    logic [OPCODE_W-1:0] opcode_q;
    classe_t             classe;
    logic [5:0]          op6;
    logic                op_alto;
    logic                hd_expira;

    assign op6     = 6'(opcode_q);
    assign op_alto = (opcode_q >> 6) != '0;

`ifdef HD_TIMEOUT_EN
    localparam int CNT_W = $clog2(HD_TIMEOUT) + 1;
    logic [CNT_W-1:0] hd_cnt;

    // WAIT_HD cycle counter: cleared while in EXEC (the only way into WAIT_HD)
    always_ff @(posedge clock) begin
        if (reset || estado == EXEC)
            hd_cnt <= '0;
        else if (estado == WAIT_HD)
            hd_cnt <= hd_cnt + 1'b1;
    end

    assign hd_expira = (estado == WAIT_HD) && !HdReady &&
                       (hd_cnt == CNT_W'(HD_TIMEOUT - 1));
`else
    assign hd_expira = 1'b0;
`endif

    // State and latched opcode register
    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= FETCH;
            opcode_q <= '0;
        end else begin
            estado <= proximo;
            if (estado == DECODE)
                opcode_q <= Opcode;
        end
    end

    // Instruction class from the latched opcode; wider opcodes must be zero above bit 5
    always_comb begin
        classe = C_OTHER;
        if (!op_alto) begin
            case (op6)
                6'b000000, 6'b000001, 6'b000100, 6'b001101,
                6'b001111, 6'b010000, 6'b010001, 6'b010010: classe = C_ALUR;
                6'b000010, 6'b000011, 6'b010100:            classe = C_ALUI;
                6'b000110: classe = C_LOAD;
                6'b000111: classe = C_STORE;
                6'b000101: classe = C_JUMP;
                6'b001010, 6'b001011: classe = C_BRANCH;
                6'b010011: classe = C_JR;
                6'b001000: classe = C_IN;
                6'b001001: classe = C_OUT;
                6'b011110: classe = C_HDW;
                6'b011111: classe = C_HDR;
                6'b011001: classe = C_HALT;
                default:   classe = C_OTHER;
            endcase
        end
    end

    // Next state and Moore outputs decoded from state and instruction class
    always_comb begin
        proximo  = estado;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        OpIO     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        AluSrc   = 1'b0;
        RegDst   = 1'b0;
        Desvio   = 1'b0;
        TypeJR   = 1'b0;
        WriteHD  = 1'b0;
        Halt     = 1'b0;
        Mem2Reg  = 2'b10;
        OpALU    = '0;
        HdErro   = 1'b0;
        case (estado)
            FETCH: begin
                IRWrite = 1'b1;
                proximo = DECODE;
            end
            DECODE: proximo = EXEC;
            EXEC: begin
                OpALU   = OPALU_W'(opcode_q);
                proximo = FETCH;
                case (classe)
                    C_ALUR:   begin RegDst = 1'b1; proximo = WB; end
                    C_ALUI:   begin AluSrc = 1'b1; proximo = WB; end
                    C_LOAD,
                    C_STORE:  begin AluSrc = 1'b1; proximo = MEM; end
                    C_JUMP:   begin Desvio = 1'b1; PCWrite = 1'b1; AluSrc = 1'b1; end
                    C_BRANCH: begin Desvio = 1'b1; PCWrite = 1'b1; end
                    C_JR: begin
                        Desvio = 1'b1; PCWrite = 1'b1; AluSrc = 1'b1; TypeJR = 1'b1;
                    end
                    C_IN:     proximo = WAIT_IN;
                    C_OUT: begin
                        OpIO = 1'b1; AluSrc = 1'b1; Mem2Reg = 2'b01; PCWrite = 1'b1;
                    end
                    C_HDW,
                    C_HDR:    proximo = WAIT_HD;
                    C_HALT:   proximo = HALTED;
                    default:  PCWrite = 1'b1;
                endcase
            end
            MEM: begin
                OpALU = OPALU_W'(opcode_q);
                if (classe == C_LOAD) begin
                    AluSrc  = 1'b1;
                    MemRead = 1'b1;
                    proximo = WB;
                end else begin
                    MemWrite = 1'b1;
                    PCWrite  = 1'b1;
                    proximo  = FETCH;
                end
            end
            WB: begin
                OpALU    = OPALU_W'(opcode_q);
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                proximo  = FETCH;
                case (classe)
                    C_ALUR:  RegDst  = 1'b1;
                    C_LOAD:  Mem2Reg = 2'b00;
                    C_IN:    begin OpIO = 1'b1; Mem2Reg = 2'b01; end
                    C_HDR:   Mem2Reg = 2'b11;
                    default: ;
                endcase
            end
            WAIT_IN: begin
                OpIO    = 1'b1;
                Halt    = 1'b1;
                Mem2Reg = 2'b01;
                if (InValid)
                    proximo = WB;
            end
            WAIT_HD: begin
                AluSrc  = 1'b1;
                Mem2Reg = 2'b11;
                if (classe == C_HDW) begin
                    MemWrite = 1'b1;
                    WriteHD  = 1'b1;
                    if (HdReady) begin
                        PCWrite = 1'b1;
                        proximo = FETCH;
                    end
                end else begin
                    MemRead = 1'b1;
                    if (HdReady)
                        proximo = WB;
                end
                // Timeout skips the instruction: retire PC without writeback
                if (hd_expira) begin
                    HdErro  = 1'b1;
                    PCWrite = 1'b1;
                    proximo = FETCH;
                end
            end
            HALTED: Halt = 1'b1;
            default: proximo = FETCH;
        endcase
        // Reset overrides any pending write from the state being abandoned
        if (reset) begin
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            WriteHD  = 1'b0;
            HdErro   = 1'b0;
        end
    end

    assign Estado = ESTADO_W'(estado);

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Self-checking bench for unidade_controle_multiciclo (default build).
module tb_unidade_controle_multiciclo;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] Opcode;
    logic       InValid, HdReady;
    logic       IRWrite, PCWrite, OpIO, MemRead, MemWrite, RegWrite;
    logic       AluSrc, RegDst, Desvio, TypeJR, WriteHD, Halt, HdErro;
    logic [1:0] Mem2Reg;
    logic [5:0] OpALU;
    logic [3:0] Estado;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    typedef struct packed {
        logic irw, pcw, opio, mr, mw, rw, as, rd, dv, jr, whd, hlt;
        logic [1:0] m2r;
        logic [5:0] alu;
        logic       err;
        logic [3:0] est;
    } ctrl_t;

    ctrl_t act;
    assign act = {IRWrite, PCWrite, OpIO, MemRead, MemWrite, RegWrite, AluSrc,
                  RegDst, Desvio, TypeJR, WriteHD, Halt, Mem2Reg, OpALU, HdErro, Estado};

    unidade_controle_multiciclo #(
        .OPCODE_W(6), .OPALU_W(6), .ESTADO_W(4), .HD_TIMEOUT(1024)
    ) dut (
        .clock(clock), .reset(reset), .Opcode(Opcode), .InValid(InValid),
        .HdReady(HdReady), .IRWrite(IRWrite), .PCWrite(PCWrite), .OpIO(OpIO),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .AluSrc(AluSrc), .RegDst(RegDst), .Desvio(Desvio), .TypeJR(TypeJR),
        .WriteHD(WriteHD), .Halt(Halt), .Mem2Reg(Mem2Reg), .OpALU(OpALU),
        .HdErro(HdErro), .Estado(Estado)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Classes: 0 ALU-R,1 ALU-I,2 LOAD,3 STORE,4 JUMP,5 BRANCH,6 JR,7 IN,8 OUT,
    //          9 HD-W,10 HD-R,11 HALT,12 other
    // Phases use the state numbering: 0 F,1 D,2 E,3 M,4 W,5 WAIT_IN,6 WAIT_HD,7 HALTED; 8 = end
    int seq [13][6];
    int m_cls, m_idx;
    logic [5:0] m_op;

    function automatic int classify(input logic [5:0] op);
        case (op)
            6'd0, 6'd1, 6'd4, 6'd13, 6'd15, 6'd16, 6'd17, 6'd18: return 0;
            6'd2, 6'd3, 6'd20: return 1;
            6'd6:  return 2;
            6'd7:  return 3;
            6'd5:  return 4;
            6'd10, 6'd11: return 5;
            6'd19: return 6;
            6'd8:  return 7;
            6'd9:  return 8;
            6'd30: return 9;
            6'd31: return 10;
            6'd25: return 11;
            default: return 12;
        endcase
    endfunction

    function automatic ctrl_t expected(input int cls, input int ph, input logic [5:0] op,
                                       input logic hdr, input logic rst);
        ctrl_t e;
        e = '0;
        e.m2r = 2'b10;
        e.est = 4'(ph);
        if (ph >= 2 && ph <= 4) e.alu = op;
        case (ph)
            0: e.irw = 1'b1;
            2: case (cls)
                   0: e.rd = 1'b1;
                   1, 2, 3: e.as = 1'b1;
                   4: begin e.dv = 1'b1; e.pcw = 1'b1; e.as = 1'b1; end
                   5: begin e.dv = 1'b1; e.pcw = 1'b1; end
                   6: begin e.dv = 1'b1; e.pcw = 1'b1; e.as = 1'b1; e.jr = 1'b1; end
                   8: begin e.opio = 1'b1; e.as = 1'b1; e.m2r = 2'b01; e.pcw = 1'b1; end
                   12: e.pcw = 1'b1;
                   default: ;
               endcase
            3: if (cls == 2) begin e.as = 1'b1; e.mr = 1'b1; end
               else begin e.mw = 1'b1; e.pcw = 1'b1; end
            4: begin
                   e.rw = 1'b1; e.pcw = 1'b1;
                   if (cls == 0) e.rd = 1'b1;
                   if (cls == 2) e.m2r = 2'b00;
                   if (cls == 7) begin e.opio = 1'b1; e.m2r = 2'b01; end
                   if (cls == 10) e.m2r = 2'b11;
               end
            5: begin e.opio = 1'b1; e.hlt = 1'b1; e.m2r = 2'b01; end
            6: begin
                   e.as = 1'b1; e.m2r = 2'b11;
                   if (cls == 9) begin e.mw = 1'b1; e.whd = 1'b1; e.pcw = hdr; end
                   else e.mr = 1'b1;
               end
            7: e.hlt = 1'b1;
            default: ;
        endcase
        if (rst) begin e.pcw = 1'b0; e.rw = 1'b0; e.mw = 1'b0; e.whd = 1'b0; end
        return e;
    endfunction

    initial begin
        seq[0]  = '{0, 1, 2, 4, 8, 8};
        seq[1]  = '{0, 1, 2, 4, 8, 8};
        seq[2]  = '{0, 1, 2, 3, 4, 8};
        seq[3]  = '{0, 1, 2, 3, 8, 8};
        seq[4]  = '{0, 1, 2, 8, 8, 8};
        seq[5]  = '{0, 1, 2, 8, 8, 8};
        seq[6]  = '{0, 1, 2, 8, 8, 8};
        seq[7]  = '{0, 1, 2, 5, 4, 8};
        seq[8]  = '{0, 1, 2, 8, 8, 8};
        seq[9]  = '{0, 1, 2, 6, 8, 8};
        seq[10] = '{0, 1, 2, 6, 4, 8};
        seq[11] = '{0, 1, 2, 7, 8, 8};
        seq[12] = '{0, 1, 2, 8, 8, 8};
        m_cls = 0; m_idx = 0; m_op = '0;
    end

    // Model advance: walk the class's phase list, holding on waits
    always @(posedge clock) begin
        int ph, n_idx, n_cls;
        logic [5:0] n_op;
        logic go;
        if (reset) begin
            m_idx <= 0; m_cls <= 0; m_op <= '0;
        end else begin
            ph = seq[m_cls][m_idx];
            n_cls = m_cls; n_op = m_op; go = 1'b1;
            case (ph)
                1: begin n_op = Opcode; n_cls = classify(Opcode); end
                5: go = InValid;
                6: go = HdReady;
                7: go = 1'b0;
                default: ;
            endcase
            n_idx = m_idx;
            if (go) begin
                n_idx = m_idx + 1;
                if (seq[n_cls][n_idx] == 8) n_idx = 0;
            end
            m_idx <= n_idx; m_cls <= n_cls; m_op <= n_op;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        ctrl_t e;
        if (chk_en) begin
            e = expected(m_cls, seq[m_cls][m_idx], m_op, HdReady, reset);
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL ctrl t=%0t op=%0h: actual=%h required=%h", $time, m_op, act, e);
            end
        end
    end

    // ---------------- directed literal checks ----------------
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, a, x);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    logic [5:0] picks [22] = '{6'd0, 6'd1, 6'd4, 6'd13, 6'd15, 6'd16, 6'd17, 6'd18,
                               6'd2, 6'd3, 6'd20, 6'd6, 6'd7, 6'd5, 6'd10, 6'd11,
                               6'd19, 6'd8, 6'd9, 6'd30, 6'd31, 6'd25};

    initial begin
        int hc;
        int k;
        reset = 1'b1; Opcode = 6'd0; InValid = 1'b0; HdReady = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0; chk_en = 1'b1;
        chk("rst_estado", 32'(Estado), 32'd0);
        chk("rst_irwrite", 32'(IRWrite), 32'd1);
        cyc(); chk("aluR_decode", 32'(Estado), 32'd1);
        cyc(); chk("aluR_exec", 32'(Estado), 32'd2);
        cyc(); chk("aluR_wb", 32'(Estado), 32'd4);
        chk("aluR_wb_en", 32'({RegWrite, PCWrite, RegDst}), 32'b111);
        Opcode = 6'b000110;
        cyc(); chk("aluR_back", 32'(Estado), 32'd0);
        cyc(); chk("ld_decode", 32'(Estado), 32'd1);
        cyc(); chk("ld_exec", 32'({Estado, PCWrite}), 32'b00100);
        cyc(); chk("ld_mem", 32'({Estado, MemRead}), 32'b00111);
        cyc(); chk("ld_wb", 32'({Estado, Mem2Reg, RegWrite}), 32'b0100001);
        Opcode = 6'b011001;
        cyc(); chk("ld_back", 32'(Estado), 32'd0);
        cyc(); cyc(); cyc();
        repeat (50) cyc();
        chk("halted", 32'({Estado, Halt}), 32'b01111);
        chk("halted_en", 32'({IRWrite, PCWrite, RegWrite, MemWrite, WriteHD}), 32'd0);
        reset = 1'b1; Opcode = 6'd0;
        cyc(); reset = 1'b0;
        chk("unhalt", 32'({Estado, IRWrite}), 32'b00001);

        // Randomized traffic; reset occasionally and always after a short HALT
        hc = 0;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            if (seq[m_cls][m_idx] == 7) hc++; else hc = 0;
            k = $urandom_range(0, 24);
            Opcode  = (k < 22) ? picks[k] : 6'($urandom);
            InValid = ($urandom_range(0, 3) == 0);
            HdReady = ($urandom_range(0, 3) == 0);
            reset   = (hc > 6) || ($urandom_range(0, 249) == 0);
        end
        cyc();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidade_controle_multiciclo.md
Name: unidade_controle_multiciclo

Overview:
Multicycle successor to the single-cycle opcode decoder of the YouseiOS processor. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and stalls with handshakes on console input (IN) and HD transfers (Read/Write). It emits one-hot-per-phase datapath controls instead of static per-opcode levels, so PC, IR, register file and memories are written only in the correct cycle. It sits between the instruction register and the datapath muxes/enables.

Parameters:
OPCODE_W, 6, opcode width; opcode values below are given at width 6 and zero-extended if wider.
OPALU_W, 6, width of OpALU.
ESTADO_W, 4, width of Estado debug output; must be >= 4.
HD_TIMEOUT, 1024, WAIT_HD cycle limit; used only with HD_TIMEOUT_EN.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
Opcode  in  OPCODE_W  opcode from instruction memory; sampled in DECODE
InValid  in  1  console input confirmed; one-cycle pulse or level
HdReady  in  1  HD transfer complete
IRWrite, PCWrite, OpIO, MemRead, MemWrite, RegWrite, AluSrc, RegDst, Desvio, TypeJR, WriteHD, Halt  out  1 each  datapath controls
Mem2Reg  out  2  writeback select: 00 mem, 01 IO, 10 ALU, 11 HD
OpALU  out  OPALU_W  ALU operation code
HdErro  out  1  HD timeout pulse; tied 0 without the macro
Estado  out  ESTADO_W  current state encoding

Behaviour:
- Only reset is synchronous. With reset high at a rising edge: state becomes FETCH and opcode_q becomes 0. The reset cycle is a valid FETCH.
- Outputs are Moore outputs, decoded from state and opcode_q. Unlisted outputs are 0. Mem2Reg defaults to 10. OpALU is 0 outside EXEC/MEM/WB.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, WAIT_IN=5, WAIT_HD=6, HALTED=7.
- FETCH: IRWrite=1. Next state is DECODE.
- DECODE: opcode_q <= Opcode. Next state is EXEC.
- EXEC/MEM/WB: OpALU = opcode_q, resized to OPALU_W.
- Instruction classes, by opcode_q:
  - ALU-R (000000, 000001, 000100, 001101, 001111, 010000, 010001, 010010): EXEC with RegDst=1, AluSrc=0, then WB with RegDst=1, RegWrite=1, PCWrite=1, then FETCH.
  - ALU-I (000010 ADDI, 000011 MOVE, 010100 SUBI): EXEC with AluSrc=1, then WB with RegWrite=1, PCWrite=1, then FETCH.
  - LOAD 000110: EXEC with AluSrc=1, then MEM with AluSrc=1, MemRead=1, then WB with Mem2Reg=00, RegWrite=1, PCWrite=1, then FETCH.
  - STORE 000111: EXEC with AluSrc=1, then MEM with MemWrite=1, PCWrite=1, then FETCH.
  - JUMP 000101, BEQ 001010, BNE 001011: EXEC with Desvio=1, PCWrite=1, then FETCH. AluSrc=1 for JUMP, 0 for BEQ/BNE. The branch condition is resolved in the datapath.
  - JR 010011: as JUMP plus TypeJR=1.
  - IN 001000: EXEC, then WAIT_IN with OpIO=1, Halt=1, Mem2Reg=01. Stays in WAIT_IN while InValid=0. When InValid=1, goes to WB with OpIO=1, Mem2Reg=01, RegWrite=1, PCWrite=1, then FETCH.
  - OUT 001001: EXEC with OpIO=1, AluSrc=1, Mem2Reg=01, PCWrite=1, then FETCH.
  - HD Write 011110: EXEC, then WAIT_HD with AluSrc=1, Mem2Reg=11, MemWrite=1, WriteHD=1. Leaves on HdReady=1 in the same cycle: PCWrite=1 in that cycle, then FETCH.
  - HD Read 011111: EXEC, then WAIT_HD with AluSrc=1, Mem2Reg=11, MemRead=1. When HdReady=1, goes to WB with Mem2Reg=11, RegWrite=1, PCWrite=1, then FETCH.
  - HALT 011001: EXEC, then HALTED. HALTED drives Halt=1 and no other enables, and is left only by reset.
  - All other opcodes (NOP, OS opcodes 010101–011101, undefined): EXEC with PCWrite=1, then FETCH.
- Latencies in cycles: ALU = 4, LOAD = 5, STORE = 4, branch = 3, OUT = 3, IN = 4 + cycles waiting for InValid.
- PCWrite is asserted for exactly one cycle per retired instruction.
- InValid and HdReady are ignored outside WAIT_IN and WAIT_HD respectively.
- If InValid arrives in the same cycle the FSM enters WAIT_IN, it is not seen until the next cycle.
- Reset asserted during WAIT_IN, WAIT_HD or HALTED returns to FETCH with no write enables issued in that cycle.

Optional Feature:
HD_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT_HD and increments each cycle in WAIT_HD. If the counter reaches HD_TIMEOUT-1 with HdReady=0, the FSM:
  - pulses HdErro=1 for one cycle;
  - asserts PCWrite=1 in that cycle, skipping the instruction;
  - asserts no RegWrite;
  - goes to FETCH.
  HdReady in the expiry cycle takes priority over the timeout.
- Undefined: WAIT_HD waits indefinitely and HdErro is constant 0.

Test Plan:
- Reset, then Opcode=000000 held → Estado sequence 0,1,2,4,0; RegWrite=1 and PCWrite=1 only in the WB cycle; RegDst=1 there.
- LOAD 000110 → MemRead=1 in MEM (Estado=3); WB has Mem2Reg=00 with RegWrite=1; 5 cycles total.
- IN 001000 with InValid held low for 10 cycles, then pulsed → Halt=1 and OpIO=1 for those 10 cycles; then one WB with Mem2Reg=01, RegWrite=1.
- HD Write 011110 with HdReady after 3 cycles → WriteHD=1 and MemWrite=1 for 3 cycles, PCWrite=1 on the HdReady cycle, then FETCH.
- HALT 011001 → Halt=1 in HALTED for 50 cycles with all enables 0; reset → FETCH, IRWrite=1.
- With HD_TIMEOUT_EN and HD_TIMEOUT=8, HD Read with HdReady=0 → HdErro pulses 8 cycles after WAIT_HD entry, PCWrite=1, RegWrite stays 0.
